adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 32, operand/result width; SHALL equal the shared adder width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_ready  output  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  N_REQ*WIDTH  packed operand A, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  N_REQ*WIDTH  packed operand B, same packing.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  consumer accepts result.
REQ-011 resp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
REQ-012 resp_id  output  $clog2(N_REQ)  index of requester that owns resp_sum.
REQ-013 busy  output  1  high while a result is held (state FULL).

Function
REQ-014 Shares one adder between N_REQ requesters; one operation accepted per cycle at most.
REQ-015 FSM states: IDLE (no result held), FULL (result held, resp_valid=1).
REQ-016 Accept condition: req_valid[g] && req_ready[g], g = round-robin winner.
REQ-017 req_ready[g] SHALL be high only for winner g, only when state==IDLE or (state==FULL && resp_ready); combinationally derived from req_valid, pointer, state, resp_ready.
REQ-018 Round-robin: search starts at pointer ptr, ascending, wrapping N_REQ-1 -> 0; first asserted req_valid wins.
REQ-019 On accept of g, ptr <= (g+1) mod N_REQ; ptr unchanged when nothing accepted.
REQ-020 On accept, operands of g and index g SHALL be registered; resp_valid high the next cycle (latency 1 cycle).
REQ-021 resp_sum SHALL be the shared adder's output driven from the registered operands; overflow carry discarded (wrap-around modulo 2^WIDTH).
REQ-022 resp_sum, resp_id stable while resp_valid && !resp_ready.
REQ-023 Transitions: IDLE+accept -> FULL; FULL+resp_ready+accept -> FULL (new result next cycle, back-to-back throughput 1/cycle); FULL+resp_ready+no accept -> IDLE; FULL+!resp_ready -> FULL, no accept.
REQ-024 Requester dropping req_valid before acceptance SHALL NOT be granted; no request is lost once accepted.
REQ-025 busy == (state==FULL).

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, resp_valid=0, busy=0, ptr=0, operand registers=0, resp_id=0, regardless of clock.
REQ-027 Result held at reset assertion SHALL be discarded; no response emitted for it after release.
REQ-028 First edge after rst_n release may accept a request (req_ready valid from first cycle).

Structure
REQ-029 Shared package holds WIDTH default (32), N_REQ default, state enum {IDLE, FULL}, and id width function/constant.
REQ-030 Exactly one sub-module: existing adder_32bit instantiated once as the shared datapath; no other arithmetic in the block.
REQ-031 Round-robin winner logic is combinational inside adder_arbiter; no extra sub-module.

Verification
REQ-032 Single request: req_valid=0001, a=5, b=7 -> req_ready=0001 same cycle; next cycle resp_valid=1, resp_sum=12, resp_id=0.
REQ-033 Wrap-around: a=0xFFFFFFFF, b=0x00000002 -> resp_sum=0x00000001, no extra output.
REQ-034 Fairness: req_valid=1111 continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,... one result per cycle.
REQ-035 Backpressure: resp_ready=0 for 3 cycles with FULL, req_valid=0010 -> req_ready=0, resp_sum/resp_id unchanged; resp_ready=1 -> req 1 accepted same cycle, its sum next cycle.
REQ-036 Skip/pointer: ptr=2, req_valid=0011 -> requester 0 granted, ptr becomes 1.
REQ-037 Reset mid-operation: rst_n low while FULL (resp_sum=12) -> resp_valid=0 asynchronously; after release, req_valid=1000 granted (ptr=0 search), no stale response.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter that fronts a single
// adder.
package adder_arbiter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N_REQ = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  // Index width for a requester id; never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Shared combinational datapath adder; the carry out is dropped so the sum
// wraps modulo 2^WIDTH.
module adder_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among N_REQ requesters; one-deep
// result holding stage with a ready/valid response port.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*WIDTH-1:0]        req_a,
  input  logic [N_REQ*WIDTH-1:0]        req_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [WIDTH-1:0]              resp_sum,
  output logic [id_width(N_REQ)-1:0]    resp_id,
  output logic                          busy
);

  localparam int IDW = id_width(N_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [IDW-1:0]   grant_s;
  logic [IDW-1:0]   idx_s;
  logic             hit_s;
  logic             found_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s   = IDW'((int'(ptr_q) + k) % N_REQ);
      hit_s   = !found_s && req_valid[idx_s];
      grant_s = hit_s ? idx_s : grant_s;
      found_s = found_s | hit_s;
    end
  end

  // A new operation may enter only when the holding stage is empty or draining.
  assign can_accept_s = (state_q == IDLE) || resp_ready;
  assign accept_s     = found_s && can_accept_s;

  // One-hot ready towards the winning requester.
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux for the winner.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel_a_s = (grant_s == IDW'(k)) ? req_a[k*WIDTH +: WIDTH] : sel_a_s;
      sel_b_s = (grant_s == IDW'(k)) ? req_b[k*WIDTH +: WIDTH] : sel_b_s;
    end
  end

  // Next-state, pointer and captured-operand logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    if (accept_s) begin
      ptr_d = (grant_s == LAST_ID) ? '0 : grant_s + IDW'(1);
      id_d  = grant_s;
      a_d   = sel_a_s;
      b_d   = sel_b_s;
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      IDLE:    state_d = accept_s ? FULL : IDLE;
      FULL:    state_d = (resp_ready && !accept_s) ? IDLE : FULL;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and operand registers; reset drops any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  adder_32bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (resp_sum)
  );

  assign resp_valid = (state_q == FULL);
  assign busy       = (state_q == FULL);
  assign resp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, single op, wrap-around, skip,
// fairness, backpressure, dropped request and mid-operation reset.
module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_sum;
  logic [1:0]  resp_id;
  logic        busy;

  logic [31:0] tb_a [4];
  logic [31:0] tb_b [4];

  int n_cmp = 0;
  int n_bad = 0;

  assign req_a = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
  assign req_b = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

  adder_arbiter #(.N_REQ(4), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tb_a[i] = 32'd0;
      tb_b[i] = 32'd0;
    end
    #12;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d exp 0", resp_id); end
    n_cmp++; if (resp_sum !== 32'd0) begin n_bad++; $display("FAIL reset_sum: got %0d exp 0", resp_sum); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    tb_a[0] = 32'd5; tb_b[0] = 32'd7;
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    n_cmp++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_valid: got v=%b busy=%b exp 1/1", resp_valid, busy); end
    n_cmp++; if (resp_sum !== 32'd12) begin n_bad++; $display("FAIL single_sum: got %0d exp 12", resp_sum); end
    n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d exp 0", resp_id); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b exp 0", resp_valid); end
  endtask

  task automatic test_wrap();
    tb_a[1] = 32'hFFFF_FFFF; tb_b[1] = 32'h0000_0002;
    req_valid = 4'b0010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ready: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    n_cmp++; if (resp_sum !== 32'h0000_0001 || resp_id !== 2'd1) begin n_bad++; $display("FAIL wrap_sum: got %h/%0d exp 00000001/1", resp_sum, resp_id); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_extra: got %b exp 0", resp_valid); end
  endtask

  task automatic test_skip();
    // pointer sits at 2 here
    tb_a[0] = 32'd10;  tb_b[0] = 32'd20;
    tb_a[1] = 32'd100; tb_b[1] = 32'd1;
    req_valid = 4'b0011;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL skip_ready0: got %b exp 0001", req_ready); end
    step();
    n_cmp++; if (resp_sum !== 32'd30 || resp_id !== 2'd0) begin n_bad++; $display("FAIL skip_resp0: got %0d/%0d exp 30/0", resp_sum, resp_id); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL skip_ptr1: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    n_cmp++; if (resp_sum !== 32'd101 || resp_id !== 2'd1) begin n_bad++; $display("FAIL skip_resp1: got %0d/%0d exp 101/1", resp_sum, resp_id); end
    step();
  endtask

  task automatic test_fairness();
    logic [31:0] exp_sum [4];
    logic [3:0]  exp_rdy;
    exp_sum = '{32'd1, 32'd18, 32'd35, 32'd52};
    for (int i = 0; i < 4; i++) begin
      tb_a[i] = 32'(i + 1);
      tb_b[i] = 32'(16 * i);
    end
    // pointer at 2: park it at 0 via requester 3
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL fair_setup: got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL fair_ready%0d: got %b exp %b", k, req_ready, exp_rdy); end
      step();
      n_cmp++; if (resp_valid !== 1'b1 || resp_id !== 2'(k % 4) || resp_sum !== exp_sum[k % 4]) begin
        n_bad++; $display("FAIL fair_resp%0d: got v=%b id=%0d sum=%0d exp 1/%0d/%0d", k, resp_valid, resp_id, resp_sum, k % 4, exp_sum[k % 4]);
      end
    end
    req_valid = 4'b0000;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL fair_drain: got %b exp 0", resp_valid); end
  endtask

  task automatic test_backpressure();
    tb_a[0] = 32'd5; tb_b[0] = 32'd7;
    tb_a[1] = 32'd3; tb_b[1] = 32'd4;
    req_valid = 4'b0001;
    step();
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready%0d: got %b exp 0000", k, req_ready); end
      n_cmp++; if (resp_valid !== 1'b1 || resp_sum !== 32'd12 || resp_id !== 2'd0) begin
        n_bad++; $display("FAIL bp_hold%0d: got v=%b sum=%0d id=%0d exp 1/12/0", k, resp_valid, resp_sum, resp_id);
      end
      step();
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release: got %b exp 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    n_cmp++; if (resp_sum !== 32'd7 || resp_id !== 2'd1) begin n_bad++; $display("FAIL bp_next: got %0d/%0d exp 7/1", resp_sum, resp_id); end
    step();
  endtask

  task automatic test_drop();
    // pointer at 2: requester 2 raises and withdraws before the edge
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL drop_offer: got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL drop_grant: got %b exp 0", resp_valid); end
  endtask

  task automatic test_reset_mid();
    tb_a[0] = 32'd5; tb_b[0] = 32'd7;
    tb_a[3] = 32'd2; tb_b[3] = 32'd3;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    resp_ready = 1'b0;
    n_cmp++; if (resp_sum !== 32'd12 || resp_valid !== 1'b1) begin n_bad++; $display("FAIL rm_full: got %0d/%b exp 12/1", resp_sum, resp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 2'd0) begin
      n_bad++; $display("FAIL rm_async: got v=%b busy=%b id=%0d exp 0/0/0", resp_valid, busy, resp_id);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale: got %b exp 0", resp_valid); end
    req_valid = 4'b1000;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL rm_ready: got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b0000;
    n_cmp++; if (resp_sum !== 32'd5 || resp_id !== 2'd3) begin n_bad++; $display("FAIL rm_resp: got %0d/%0d exp 5/3", resp_sum, resp_id); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_drain: got %b exp 0", resp_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_skip();
    test_fairness();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
